// File: rtl/modport_slave.sv
// AHB-Lite word RAM slave: zero-wait OKAY data phase; illegal accesses get a two-cycle ERROR.
// Latency: read data and write commit in the cycle after the address phase; stalls (hready=0) only in ERROR cycle 1.
module modport_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [1:0]            hresp
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE_OK = 2'b00,
        ERR1    = 2'b01,
        ERR2    = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  dp_vld;
    logic                  dp_write;
    logic [3:0]            dp_be;
    logic [IW-1:0]         dp_idx;

    logic                  accept;
    logic                  illegal;
    logic [3:0]            be_d;
    logic                  unused_sigs;

    // Burst type, protection and the BUSY/IDLE distinction do not affect this slave.
    assign unused_sigs = ^{hburst, hprot, htrans[0]};

    assign accept = hsel && htrans[1] && hready;

    always_comb begin
        illegal = 1'b0;
        be_d    = 4'b0000;
        case (hsize)
            3'b000: be_d = 4'b0001 << haddr[1:0];
            3'b001: begin
                be_d    = haddr[1] ? 4'b1100 : 4'b0011;
                illegal = haddr[0];
            end
            3'b010: begin
                be_d    = 4'b1111;
                illegal = |haddr[1:0];
            end
            default: illegal = 1'b1;
        endcase
        if (haddr >= ADDR_LIMIT) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        state_d = IDLE_OK;
        hready  = 1'b1;
        hresp   = 2'b00;
        case (state_q)
            ERR1: begin
                hready  = 1'b0;
                hresp   = 2'b01;
                state_d = ERR2;
            end
            ERR2: hresp = 2'b01;
            default: ;
        endcase
        if (accept && illegal) begin
            state_d = ERR1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state_q  <= IDLE_OK;
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_be    <= 4'b0000;
            dp_idx   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            // Commit at the edge ending the write data phase, so a following read sees it.
            if (dp_vld && dp_write) begin
                for (int n = 0; n < 4; n++) begin
                    if (dp_be[n]) begin
                        mem[dp_idx][8*n +: 8] <= hwdata[8*n +: 8];
                    end
                end
            end
            dp_vld <= accept && !illegal;
            if (accept) begin
                dp_write <= hwrite;
                dp_be    <= be_d;
                dp_idx   <= haddr[IW+1:2];
            end
        end
    end

    assign hrdata = (dp_vld && !dp_write) ? mem[dp_idx] : '0;

endmodule

// File: tb/tb_modport_slave.sv
// Directed bench for modport_slave: one task per scenario with hand-computed expectations.
module tb_modport_slave;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    int n_cmp = 0;
    int n_err = 0;

    modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .hsel   (hsel),
        .haddr  (haddr),
        .htrans (htrans),
        .hwrite (hwrite),
        .hsize  (hsize),
        .hburst (hburst),
        .hprot  (hprot),
        .hwdata (hwdata),
        .hready (hready),
        .hrdata (hrdata),
        .hresp  (hresp)
    );

    always #5 hclk = ~hclk;

    // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge hclk);
        #1;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hwdata = wdata;
        @(negedge hclk);
    endtask

    task automatic test_reset();
        hresetn = 1'b1;
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hready !== 1'b1) begin n_err++; $display("FAIL reset_hready: got %b expected 1", hready); end
        n_cmp++;
        if (hresp !== 2'b00) begin n_err++; $display("FAIL reset_hresp: got %b expected 00", hresp); end
        n_cmp++;
        if (hrdata !== 32'h0) begin n_err++; $display("FAIL reset_hrdata: got %h expected 00000000", hrdata); end
        hresetn = 1'b0;
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h10, 32'h0);
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h0 || hresp !== 2'b00) begin
            n_err++; $display("FAIL reset_read10: got %h/%b expected 00000000/00", hrdata, hresp);
        end
    endtask

    task automatic test_word();
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h10, 32'h0);
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h10, 32'hDEADBEEF);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            n_err++; $display("FAIL word_wr_phase: got %b/%b expected 1/00", hready, hresp);
        end
        n_cmp++;
        if (hrdata !== 32'h0) begin n_err++; $display("FAIL word_wr_hrdata: got %h expected 00000000", hrdata); end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'hDEADBEEF || hready !== 1'b1 || hresp !== 2'b00) begin
            n_err++; $display("FAIL word_read: got %h/%b/%b expected deadbeef/1/00", hrdata, hready, hresp);
        end
    endtask

    task automatic test_lanes();
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h20, 32'h0);
        step(1'b1, NONSEQ, 1'b1, SZ_B, 32'h21, 32'h11223344);
        step(1'b1, NONSEQ, 1'b1, SZ_H, 32'h22, 32'h0000AA00);
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h20, 32'h55660000);
        step(1'b1, NONSEQ, 1'b0, SZ_B, 32'h23, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h5566AA44) begin n_err++; $display("FAIL lanes_word_read: got %h expected 5566aa44", hrdata); end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h5566AA44) begin n_err++; $display("FAIL lanes_byte_read: got %h expected 5566aa44", hrdata); end
        n_cmp++;
        if (hresp !== 2'b00) begin n_err++; $display("FAIL lanes_hresp: got %b expected 00", hresp); end
    endtask

    task automatic test_no_select();
        step(1'b0, NONSEQ, 1'b1, SZ_W, 32'h20, 32'h0);
        step(1'b1, IDLE, 1'b1, SZ_W, 32'h20, 32'hFFFFFFFF);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            n_err++; $display("FAIL nosel_phase: got %b/%b expected 1/00", hready, hresp);
        end
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h20, 32'hFFFFFFFF);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            n_err++; $display("FAIL idle_phase: got %b/%b expected 1/00", hready, hresp);
        end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h5566AA44) begin n_err++; $display("FAIL nosel_mem: got %h expected 5566aa44", hrdata); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h30, 32'h0);
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h30, 32'hCAFEF00D);
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_read: got %h expected cafef00d", hrdata); end
    endtask

    task automatic test_error();
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h00, 32'h0);
        // misaligned word write; the write presented during the stall must be ignored
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h02, 32'hA5A50001);
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h00, 32'hFFFFFFFF);
        n_cmp++;
        if (hready !== 1'b0 || hresp !== 2'b01 || hrdata !== 32'h0) begin
            n_err++; $display("FAIL mis_err1: got %b/%b/%h expected 0/01/00000000", hready, hresp, hrdata);
        end
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h00, 32'hBAD0BAD0);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b01 || hrdata !== 32'h0) begin
            n_err++; $display("FAIL mis_err2: got %b/%b/%h expected 1/01/00000000", hready, hresp, hrdata);
        end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'hA5A50001 || hready !== 1'b1 || hresp !== 2'b00) begin
            n_err++; $display("FAIL mis_after: got %h/%b/%b expected a5a50001/1/00", hrdata, hready, hresp);
        end
        // out of range word write at 0x400
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h400, 32'h0);
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF);
        n_cmp++;
        if (hready !== 1'b0 || hresp !== 2'b01) begin
            n_err++; $display("FAIL oor_err1: got %b/%b expected 0/01", hready, hresp);
        end
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h00, 32'hFFFFFFFF);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b01) begin
            n_err++; $display("FAIL oor_err2: got %b/%b expected 1/01", hready, hresp);
        end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'hA5A50001 || hresp !== 2'b00) begin
            n_err++; $display("FAIL oor_after: got %h/%b expected a5a50001/00", hrdata, hresp);
        end
        // misaligned halfword and oversize transfers
        step(1'b1, NONSEQ, 1'b0, SZ_H, 32'h21, 32'h0);
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hready !== 1'b0 || hresp !== 2'b01) begin
            n_err++; $display("FAIL half_mis_err1: got %b/%b expected 0/01", hready, hresp);
        end
        step(1'b1, NONSEQ, 1'b0, 3'b011, 32'h20, 32'h0);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b01) begin
            n_err++; $display("FAIL half_mis_err2: got %b/%b expected 1/01", hready, hresp);
        end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hready !== 1'b0 || hresp !== 2'b01) begin
            n_err++; $display("FAIL oversize_err1: got %b/%b expected 0/01", hready, hresp);
        end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            n_err++; $display("FAIL err_recover: got %b/%b expected 1/00", hready, hresp);
        end
    endtask

    task automatic test_burst();
        hburst = 3'b011;
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h40, 32'h0);
        step(1'b1, SEQ, 1'b1, SZ_W, 32'h44, 32'h11110040);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin n_err++; $display("FAIL burst_b0: got %b/%b expected 1/00", hready, hresp); end
        step(1'b1, BUSY, 1'b1, SZ_W, 32'h48, 32'h11110044);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin n_err++; $display("FAIL burst_b1: got %b/%b expected 1/00", hready, hresp); end
        step(1'b1, SEQ, 1'b1, SZ_W, 32'h48, 32'hDEAD0000);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin n_err++; $display("FAIL burst_busy: got %b/%b expected 1/00", hready, hresp); end
        step(1'b1, SEQ, 1'b1, SZ_W, 32'h4C, 32'h11110048);
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin n_err++; $display("FAIL burst_b2: got %b/%b expected 1/00", hready, hresp); end
        hburst = 3'b000;
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h40, 32'h1111004C);
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h44, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h11110040) begin n_err++; $display("FAIL burst_rd40: got %h expected 11110040", hrdata); end
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h48, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h11110044) begin n_err++; $display("FAIL burst_rd44: got %h expected 11110044", hrdata); end
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h4C, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h11110048) begin n_err++; $display("FAIL burst_rd48: got %h expected 11110048", hrdata); end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h1111004C) begin n_err++; $display("FAIL burst_rd4c: got %h expected 1111004c", hrdata); end
    endtask

    task automatic test_reset_abort();
        step(1'b1, NONSEQ, 1'b1, SZ_W, 32'h50, 32'h0);
        hresetn = 1'b1;
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h77777777);
        hresetn = 1'b0;
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h50, 32'h0);
        step(1'b1, NONSEQ, 1'b0, SZ_W, 32'h10, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h0) begin n_err++; $display("FAIL abort_rd50: got %h expected 00000000", hrdata); end
        step(1'b0, IDLE, 1'b0, SZ_W, 32'h0, 32'h0);
        n_cmp++;
        if (hrdata !== 32'h0) begin n_err++; $display("FAIL abort_rd10_cleared: got %h expected 00000000", hrdata); end
    endtask

    initial begin
        hresetn = 1'b1;
        hsel    = 1'b0;
        haddr   = 32'h0;
        htrans  = IDLE;
        hwrite  = 1'b0;
        hsize   = SZ_W;
        hburst  = 3'b000;
        hprot   = 4'b0011;
        hwdata  = 32'h0;
        test_reset();
        test_word();
        test_lanes();
        test_no_select();
        test_back_to_back();
        test_error();
        test_burst();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/modport_slave.md
Name: modport_slave

Overview:
- AHB-Lite single-slave memory: 32-bit word-organised RAM behind an AHB-Lite slave port.
- Driven by the testbench master through the driver clocking view and observed by the monitor view.
- Zero-wait-state OKAY transfers; two-cycle ERROR response for illegal accesses.
- Supports byte, halfword and word transfers with little-endian byte lanes.

Parameters:
- ADDR_WIDTH, 32: width of haddr.
- DATA_WIDTH, 32: width of hwdata/hrdata. Only the value 32 is supported.
- MEM_DEPTH, 256: number of DATA_WIDTH-bit words. The valid byte range is 0 to MEM_DEPTH*4-1.

Ports:
- hclk  input  1  system clock; all state changes on its rising edge.
- hresetn  input  1  reset, synchronous, active-high (asserted = 1), sampled on the rising edge of hclk.
- hsel  input  1  slave select.
- haddr  input  ADDR_WIDTH  byte address, address phase.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write, 0 = read.
- hsize  input  3  000 byte, 001 halfword, 010 word.
- hburst  input  3  burst type; accepted, no effect on behaviour.
- hprot  input  4  protection; ignored.
- hwdata  input  DATA_WIDTH  write data, data phase.
- hready  output  1  transfer-done / slave ready.
- hrdata  output  DATA_WIDTH  read data, data phase.
- hresp  output  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset (hresetn=1 at a clock edge):
  - hready=1, hresp=00, hrdata=0.
  - Pending data-phase registers cleared, so no transfer is pending.
  - All memory words cleared to 0.
  - Reset asserted mid-transfer aborts that transfer; a pending write is not committed.
- Transfer acceptance: an address phase is accepted on a rising edge where hsel=1, htrans[1]=1 and hready=1. The block registers haddr, hwrite and hsize into data-phase registers.
- IDLE or BUSY with hsel=1, or any cycle with hsel=0: no transfer. The next cycle gives hready=1, hresp=OKAY.
- Legality check at acceptance. The transfer is illegal if any of the following holds:
  - hsize>010;
  - misaligned: halfword with haddr[0]=1, or word with haddr[1:0]!=00;
  - haddr >= MEM_DEPTH*4.
- Legal write: during the data phase hready=1, hresp=00. At the edge ending the data phase, only the addressed byte lanes of mem[addr>>2] are updated:
  - byte: lane haddr[1:0];
  - halfword: lanes {haddr[1],0} and {haddr[1],1};
  - word: all lanes.
  - Lane n is hwdata[8n+7:8n].
- Legal read: during the data phase hready=1, hresp=00, hrdata=mem[addr>>2], the full word regardless of hsize; the master picks the lanes.
  - Outside a read data phase, hrdata=0.
- Back-to-back write then read of the same address: the read returns the newly written data, because the write commits at the edge that starts the read data phase.
- Illegal transfer: two-cycle ERROR response.
  - Cycle 1: hready=0, hresp=01.
  - Cycle 2: hready=1, hresp=01.
  - Memory is not modified and hrdata=0.
  - During cycle 1 (hready=0) no new address phase is accepted. The address phase presented in cycle 2 is accepted normally.
- Response FSM, three states:
  - IDLE_OK, entered after reset.
  - ERR1: entered from any state when an illegal transfer is accepted. Its outputs are cycle 1 of the ERROR response.
  - ERR2: always entered from ERR1. Its outputs are cycle 2 of the ERROR response.
  - From ERR2 or IDLE_OK the next state is ERR1 if an illegal transfer is accepted, otherwise IDLE_OK.
- Bursts: each beat (NONSEQ/SEQ) is handled independently with the master-supplied address; no wrap computation inside the slave. A BUSY beat inside a burst produces an OKAY, no-transfer data phase.

Test Plan:
- Reset: hresetn=1 for 2 cycles -> hready=1, hresp=00, hrdata=0. A read of address 0x10 afterwards returns 0x00000000.
- Word write/read: NONSEQ write 0x0000_0010 data 0xDEADBEEF, then NONSEQ read 0x10 -> hrdata=0xDEADBEEF, hresp=00, hready=1 every cycle.
- Byte/halfword lanes:
  - word 0x11223344 at 0x20;
  - byte write 0xAA at 0x21 (hwdata=0x0000AA00);
  - halfword write 0x5566 at 0x22 (hwdata=0x55660000);
  - read 0x20 -> 0x5566AA44.
- Back-to-back: write 0x30=0xCAFEF00D immediately followed by read 0x30 -> read data phase shows 0xCAFEF00D.
- Error cases: word access at 0x02, and word access at MEM_DEPTH*4 (0x400) -> each gives hready=0/hresp=01, then hready=1/hresp=01, with memory unchanged. A following legal read of 0x00 returns OKAY.
- INCR4 burst: writes to 0x40, 0x44, 0x48, 0x4C with a BUSY beat inserted -> zero wait states, all OKAY, and read-back matches.
